// File: rtl/armleocpu_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Quotient and remainder are produced together; divide-by-zero and signed overflow finish in one edge.
module armleocpu_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid,
    input  logic            kill,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   counter;
    logic [XLEN:0]   r_acc;
    logic [XLEN-1:0] q_acc;
    logic [XLEN-1:0] abs_divisor;
    logic            signed_op;
    logic            sign_dividend;
    logic            sign_divisor;

    logic            start;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] abs_dividend_in;
    logic [XLEN-1:0] abs_divisor_in;
    logic [XLEN:0]   r_shift;
    logic            r_ge;
    logic [XLEN:0]   r_step;
    logic            neg_q;
    logic            neg_r;

    assign busy = (state != IDLE);

    always_comb begin
        start           = valid & ~kill;
        div_zero        = (divisor == '0);
        overflow        = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
        abs_dividend_in = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
        abs_divisor_in  = (is_signed && divisor[XLEN-1]) ? -divisor : divisor;

        // R is one bit wider than the operands so compare/subtract cannot overflow
        r_shift = {r_acc[XLEN-1:0], q_acc[XLEN-1]};
        r_ge    = (r_shift >= {1'b0, abs_divisor});
        r_step  = r_ge ? (r_shift - {1'b0, abs_divisor}) : r_shift;

        neg_q = signed_op & (sign_dividend ^ sign_divisor);
        neg_r = signed_op & sign_dividend;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !div_zero && !overflow)
                    state_nxt = CALC;
            end
            CALC: begin
                if (kill)
                    state_nxt = IDLE;
                else if (counter == LAST_ITER)
                    state_nxt = FIXUP;
            end
            FIXUP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready         <= 1'b0;
            quotient      <= '0;
            remainder     <= '0;
            counter       <= '0;
            r_acc         <= '0;
            q_acc         <= '0;
            abs_divisor   <= '0;
            signed_op     <= 1'b0;
            sign_dividend <= 1'b0;
            sign_divisor  <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        signed_op     <= is_signed;
                        sign_dividend <= dividend[XLEN-1];
                        sign_divisor  <= divisor[XLEN-1];
                        abs_divisor   <= abs_divisor_in;
                        if (div_zero) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            ready     <= 1'b1;
                        end else if (overflow) begin
                            quotient  <= dividend;
                            remainder <= '0;
                            ready     <= 1'b1;
                        end else begin
                            counter <= '0;
                            r_acc   <= '0;
                            q_acc   <= abs_dividend_in;
                        end
                    end
                end
                CALC: begin
                    if (!kill) begin
                        r_acc   <= r_step;
                        q_acc   <= {q_acc[XLEN-2:0], r_ge};
                        counter <= counter + 1'b1;
                    end
                end
                FIXUP: begin
                    // a flushed operation leaves the previous result visible
                    if (!kill) begin
                        quotient  <= neg_q ? -q_acc : q_acc;
                        remainder <= neg_r ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
                        ready     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_armleocpu_divider.sv
// Directed and small randomized checks for armleocpu_divider.
module tb_armleocpu_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        kill;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int chk_cnt = 0;
    int err_cnt = 0;

    armleocpu_divider #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .kill      (kill),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .ready     (ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // lat = index of the edge after which ready is seen (edge 0 samples valid)
    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output int lat, output int busy_cnt, output logic seen);
        @(negedge clk);
        valid = 1'b1; is_signed = s; dividend = a; divisor = b;
        @(posedge clk); #1;
        valid = 1'b0;
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        while (!ready && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
        end
        seen = ready;
        q = quotient;
        r = remainder;
    endtask

    task automatic run_vec(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eq,
                           input logic [31:0] er, input int elat);
        logic [31:0] q, r;
        int          lat, bc;
        logic        seen;
        do_op(s, a, b, q, r, lat, bc, seen);
        check({tag, "_ready"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_q"}, q, eq);
        check({tag, "_r"}, r, er);
    endtask

    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output int lat);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        lat = 0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0;
        end else if (s) begin
            q = sa / sb; r = sa % sb; lat = 33;
        end else begin
            q = a / b; r = a % b; lat = 33;
        end
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            4:       return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] q, r, eq, er;
        int          lat, bc, elat, n;
        logic        seen, s;

        rst = 1'b1; valid = 1'b0; kill = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);

        do_op(1'b0, 32'd100, 32'd7, q, r, lat, bc, seen);
        check("divu_ready", 32'(seen), 32'd1);
        check("divu_lat", 32'(lat), 32'd33);
        check("divu_busy_cycles", 32'(bc), 32'd33);
        check("divu_busy_at_ready", 32'(busy), 32'd0);
        check("divu_q", q, 32'd14);
        check("divu_r", r, 32'd2);
        @(posedge clk); #1;
        check("divu_ready_pulse", 32'(ready), 32'd0);
        check("divu_q_hold", quotient, 32'd14);

        run_vec("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        run_vec("rem_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        run_vec("div_m8_m3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFE, 33);
        run_vec("div_min_1", 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 33);
        run_vec("divu_0_5", 1'b0, 32'd0, 32'd5, 32'd0, 32'd0, 33);
        run_vec("div_5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0);
        run_vec("divu_max_0", 1'b0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_vec("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
        run_vec("divu_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);

        // kill partway through CALC: no ready, previous result kept
        @(negedge clk);
        valid = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_busy", 32'(busy), 32'd0);
        check("kill_ready", 32'(ready), 32'd0);
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) n++;
        end
        check("kill_no_ready", 32'(n), 32'd0);
        check("kill_q_kept", quotient, 32'd0);
        check("kill_r_kept", remainder, 32'h8000_0000);
        run_vec("after_kill", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        // kill together with valid in IDLE: nothing starts
        @(negedge clk);
        valid = 1'b1; kill = 1'b1; dividend = 32'd5; divisor = 32'd0;
        @(posedge clk); #1;
        valid = 1'b0; kill = 1'b0;
        check("killvalid_busy", 32'(busy), 32'd0);
        check("killvalid_ready", 32'(ready), 32'd0);
        check("killvalid_q", quotient, 32'd3);

        // valid during CALC is ignored
        @(negedge clk);
        valid = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        valid = 1'b1; dividend = 32'd5; divisor = 32'd0;
        @(negedge clk);
        valid = 1'b0;
        lat = 6;
        while (!ready && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("midvalid_ready", 32'(ready), 32'd1);
        check("midvalid_lat", 32'(lat), 32'd33);
        check("midvalid_q", quotient, 32'd14);
        check("midvalid_r", remainder, 32'd2);

        for (int i = 0; i < 300; i++) begin
            s = 1'($urandom_range(0, 1));
            dividend = pick_operand();
            divisor = pick_operand();
            model(s, dividend, divisor, eq, er, elat);
            run_vec($sformatf("rand%0d", i), s, dividend, divisor, eq, er, elat);
        end

        // async reset mid-CALC clears outputs before the next edge
        run_vec("pre_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        @(negedge clk);
        valid = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(ready), 32'd0);
        check("arst_q", quotient, 32'd0);
        check("arst_r", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec("post_rst", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
